// File: rtl/mem_arbiter_if.sv
// Shared types and the request/response/memory bundle between clients and the arbiter.
// The slave modport is the arbiter side; the master modport is the client/memory side.
package Types;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] op_t;
endpackage

interface mem_arbiter_if;
  import Types::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  addr_t      req_addr0;
  addr_t      req_addr1;
  logic [1:0] req_we;
  op_t        req_wdata0;
  op_t        req_wdata1;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  op_t        resp_rdata;
  addr_t      mem_addr;
  logic       mem_enable_write;
  op_t        mem_write_data;
  op_t        mem_read_out;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_we, req_wdata0, req_wdata1, resp_ready,
    input  mem_read_out,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_enable_write, mem_write_data
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_we, req_wdata0, req_wdata1, resp_ready,
    output mem_read_out,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_enable_write, mem_write_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port memory with a one-cycle
// read latency; at most one read is outstanding and its data is held until consumed.
module mem_arbiter
  import Types::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StResp, StHold} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  op_t    hold_q, hold_d;

  logic issue_ok;
  logic grant;
  logic gnt_port;
  logic owner_ack;

  always_comb begin
    owner_ack = bus.resp_ready[owner_q];
    // A new issue in StResp is only safe when the current data leaves this cycle.
    issue_ok  = rst_n && ((state_q == StIdle) || ((state_q == StResp) && owner_ack));

    case (bus.req_valid)
      2'b01:   gnt_port = 1'b0;
      2'b10:   gnt_port = 1'b1;
      2'b11:   gnt_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
      default: gnt_port = 1'b0;
    endcase
    grant = issue_ok && (|bus.req_valid);

    bus.req_ready        = '0;
    bus.mem_addr         = '0;
    bus.mem_enable_write = 1'b0;
    bus.mem_write_data   = '0;
    if (grant) begin
      bus.req_ready[gnt_port] = 1'b1;
      bus.mem_addr            = gnt_port ? bus.req_addr1 : bus.req_addr0;
      bus.mem_enable_write    = bus.req_we[gnt_port];
      bus.mem_write_data      = gnt_port ? bus.req_wdata1 : bus.req_wdata0;
    end

    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    if (rst_n && (state_q != StIdle)) begin
      bus.resp_valid[owner_q] = 1'b1;
      bus.resp_rdata          = (state_q == StResp) ? bus.mem_read_out : hold_q;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;

    case (state_q)
      StIdle: state_d = StIdle;
      StResp: begin
        if (owner_ack) begin
          state_d = StIdle;
        end else begin
          hold_d  = bus.mem_read_out;
          state_d = StHold;
        end
      end
      StHold: if (owner_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (grant) begin
      last_d = gnt_port;
      if (!bus.req_we[gnt_port]) begin
        state_d = StResp;
        owner_d = gnt_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule
